out_port_tx: RTL and testbench

- Serial transmitter on the processor's output side. It is the outbound counterpart to the 16-bit `in` word the bench drives into TopLevel.
- Captures each 16-bit word the datapath writes to the output register (OutputWrite strobe). Buffers the words in a small FIFO and shifts each one out as a UART-style frame on a single wire.
- Sits beside TopLevel. It is fed by the `out` bus and the OutputWrite control line.

---
 rtl/out_port_tx_pkg.sv | 25 ++
 rtl/out_port_fifo.sv | 48 ++++
 rtl/out_port_tx.sv | 133 +++++++++++++
 tb/tb_out_port_tx.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_tx_pkg.sv
// Shared definitions for the serial output-port transmitter.
// Optional parity bit is enabled with the OUT_PORT_TX_PARITY_EN macro.
package out_port_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_BITS = 16;

`ifdef OUT_PORT_TX_PARITY_EN
  localparam int FRAME_BITS = 19;
`else
  localparam int FRAME_BITS = 18;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/out_port_fifo.sv
// Synchronous FIFO buffering words for the output-port transmitter.
// Pointers carry one extra wrap bit so full and empty decode directly from them.
module out_port_fifo
  import out_port_tx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/out_port_tx.sv
// UART-style serial transmitter for words written to the processor output register.
// Define OUT_PORT_TX_PARITY_EN to append an even-parity bit before the stop bit.
module out_port_tx
  import out_port_tx_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 out_write,
  input  logic [DATA_BITS-1:0] out_data,
  input  logic                 clear_overflow,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);

  tx_state_e            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [3:0]           idx, idx_n;
  logic                 pop;
  logic                 shift_en;
  logic                 bit_last;
  logic [DATA_BITS-1:0] head;
  logic [DATA_BITS-1:0] shift_q;
`ifdef OUT_PORT_TX_PARITY_EN
  logic                 parity_q;
`endif

  out_port_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (out_write),
    .pop   (pop),
    .wdata (out_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign busy     = (state != IDLE);
  assign bit_last = (cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      // A dropped write wins over a simultaneous clear.
      if (out_write && full)  overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = bit_last ? '0 : cnt + 1'b1;
    idx_n    = idx;
    pop      = 1'b0;
    shift_en = 1'b0;
    tx       = 1'b1;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_last) begin
          state_n = DATA;
          idx_n   = '0;
        end
      end
      DATA: begin
        tx = shift_q[0];
        if (bit_last) begin
          shift_en = 1'b1;
          idx_n    = idx + 1'b1;
`ifdef OUT_PORT_TX_PARITY_EN
          if (idx == IDX_LAST) state_n = PARITY;
`else
          if (idx == IDX_LAST) state_n = STOP;
`endif
        end
      end
`ifdef OUT_PORT_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (bit_last) state_n = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when another word is waiting.
        if (bit_last) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (pop)           shift_q <= head;
    else if (shift_en) shift_q <= shift_q >> 1;
  end

`ifdef OUT_PORT_TX_PARITY_EN
  always_ff @(posedge clock) begin
    if (pop) parity_q <= even_parity(head);
  end
`endif

endmodule

// File: tb/tb_out_port_tx.sv
// Randomised and directed bench for out_port_tx against a frame-level behavioural model.
module tb_out_port_tx;

  localparam int C = 4;
  localparam int D = 4;
`ifdef OUT_PORT_TX_PARITY_EN
  localparam int FRAME = 19;
  localparam bit PAR = 1'b1;
`else
  localparam int FRAME = 18;
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME_CYC = FRAME * C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        out_write = 1'b0;
  logic [15:0] out_data = '0;
  logic        clear_overflow = 1'b0;
  logic        tx, busy, full, empty, overflow;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state: queued words, current frame word, cycles left in frame.
  logic [15:0] mq[$];
  logic [15:0] mcur = '0;
  int          mrem = 0;
  logic        movf = 1'b0;

  out_port_tx #(.DEPTH(D), .CLKS_PER_BIT(C)) dut (
    .clock          (clock),
    .reset          (reset),
    .out_write      (out_write),
    .out_data       (out_data),
    .clear_overflow (clear_overflow),
    .tx             (tx),
    .busy           (busy),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    mq.delete();
    mrem = 0;
    movf = 1'b0;
  endtask

  task automatic model_step();
    bit do_pop, drop;
    do_pop = (mq.size() > 0) && (mrem <= 1);
    drop   = out_write && (mq.size() == D);
    if (do_pop) begin
      mcur = mq.pop_front();
      mrem = FRAME_CYC;
    end else if (mrem > 0) begin
      mrem--;
    end
    if (out_write && !drop) mq.push_back(out_data);
    if (drop) movf = 1'b1;
    else if (clear_overflow) movf = 1'b0;
  endtask

  function automatic logic m_tx();
    int t, b;
    if (mrem == 0) return 1'b1;
    t = FRAME_CYC - mrem;
    b = t / C;
    if (b == 0) return 1'b0;
    if (b <= 16) return mcur[b-1];
    if (PAR && b == 17) return ^mcur;
    return 1'b1;
  endfunction

  function automatic logic [4:0] m_vec();
    return {m_tx(), mrem != 0, mq.size() == D, mq.size() == 0, movf};
  endfunction

  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if ({tx, busy, full, empty, overflow} !== 5'b10010) begin
      n_err++;
      $display("FAIL reset_values got=%b want=10010", {tx, busy, full, empty, overflow});
    end
    reset = 1'b0;
    model_reset();
    step();
    n_cmp++;
    if ({tx, busy, full, empty, overflow} !== 5'b10010) begin
      n_err++;
      $display("FAIL after_reset_idle got=%b want=10010", {tx, busy, full, empty, overflow});
    end
  endtask

  task automatic test_single();
    int busy_cnt;
    logic exp_tx;
    busy_cnt = 0;
    out_write = 1'b1;
    out_data  = 16'h7FFF;
    step();
    out_write = 1'b0;
    out_data  = 16'($urandom);
    n_cmp++;
    if (empty !== 1'b0) begin
      n_err++;
      $display("FAIL single_empty_after_write got=%b want=0", empty);
    end
    for (int i = 0; i < FRAME_CYC + 8; i++) begin
      step();
      if (busy === 1'b1) busy_cnt++;
      exp_tx = (i < FRAME_CYC) ? ((i < 4) ? 1'b0 : (i < 64) ? 1'b1 : (i < 68) ? 1'b0 : 1'b1) : 1'b1;
      n_cmp++;
      if (tx !== exp_tx || {tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL single_cycle%0d got=%b want=%b tx_want=%b", i, {tx, busy, full, empty, overflow}, m_vec(), exp_tx);
      end
      if (i == 0) begin
        n_cmp++;
        if (empty !== 1'b1 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL single_pop_edge empty=%b busy=%b want empty=1 busy=1", empty, busy);
        end
      end
    end
    n_cmp++;
    if (busy_cnt != FRAME_CYC) begin
      n_err++;
      $display("FAIL single_busy_len got=%0d want=%0d", busy_cnt, FRAME_CYC);
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt, rises;
    logic prev;
    busy_cnt = 0;
    rises = 0;
    prev = 1'b0;
    out_write = 1'b1;
    out_data  = 16'h0001;
    step();
    out_data  = 16'h8000;
    step();
    out_write = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    prev = busy;
    rises = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 2 * FRAME_CYC + 10; i++) begin
      step();
      if (busy === 1'b1) busy_cnt++;
      if (busy === 1'b1 && prev !== 1'b1) rises++;
      prev = busy;
      n_cmp++;
      if ({tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL b2b_cycle%0d got=%b want=%b", i, {tx, busy, full, empty, overflow}, m_vec());
      end
    end
    n_cmp++;
    if (busy_cnt != 2 * FRAME_CYC || rises != 1) begin
      n_err++;
      $display("FAIL b2b_busy got=%0d/%0d want=%0d/1", busy_cnt, rises, 2 * FRAME_CYC);
    end
  endtask

  task automatic test_fill_overflow();
    int guard;
    for (int i = 1; i <= 5; i++) begin
      out_write = 1'b1;
      out_data  = 16'(i * 16'h1111);
      step();
    end
    out_write = 1'b0;
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL fill_full got full=%b ovf=%b busy=%b want 1 0 1", full, overflow, busy);
    end
    out_write = 1'b1;
    out_data  = 16'h6666;
    step();
    out_write = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1 || full !== 1'b1) begin
      n_err++;
      $display("FAIL drop_sets_overflow got ovf=%b full=%b want 1 1", overflow, full);
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++;
      $display("FAIL clear_overflow got=%b want=0", overflow);
    end
    out_write = 1'b1;
    clear_overflow = 1'b1;
    out_data  = 16'h7777;
    step();
    out_write = 1'b0;
    clear_overflow = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL drop_beats_clear got=%b want=1", overflow);
    end
    guard = 0;
    while ((mrem != 0 || mq.size() != 0) && guard < 3000) begin
      step();
      guard++;
      n_cmp++;
      if ({tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL fill_drain_cycle%0d got=%b want=%b", guard, {tx, busy, full, empty, overflow}, m_vec());
      end
    end
    n_cmp++;
    if (guard >= 3000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL fill_drain_timeout busy=%b want=0", busy);
    end
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
  endtask

  task automatic test_stop_pop();
    int guard;
    out_write = 1'b1;
    out_data  = 16'hC3A1;
    step();
    out_data  = 16'h1E5B;
    step();
    out_write = 1'b0;
    guard = 0;
    while (mrem != 1 && guard < 200) begin
      step();
      guard++;
      n_cmp++;
      if ({tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL stop_pop_pre%0d got=%b want=%b", guard, {tx, busy, full, empty, overflow}, m_vec());
      end
    end
    out_write = 1'b1;
    out_data  = 16'h9D42;
    step();
    out_write = 1'b0;
    n_cmp++;
    if (empty !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || tx !== 1'b0 || guard >= 200) begin
      n_err++;
      $display("FAIL stop_pop_edge got empty=%b full=%b ovf=%b tx=%b want 0 0 0 0", empty, full, overflow, tx);
    end
    guard = 0;
    while ((mrem != 0 || mq.size() != 0) && guard < 1000) begin
      step();
      guard++;
      n_cmp++;
      if ({tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL stop_pop_drain%0d got=%b want=%b", guard, {tx, busy, full, empty, overflow}, m_vec());
      end
    end
    n_cmp++;
    if (guard >= 1000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL stop_pop_timeout busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    out_write = 1'b1;
    out_data  = 16'hA5A5;
    step();
    out_data  = 16'h1234;
    step();
    out_write = 1'b0;
    for (int i = 0; i < 9; i++) step();
    n_cmp++;
    if (tx !== 1'b0 || busy !== 1'b1 || tx !== m_tx()) begin
      n_err++;
      $display("FAIL mid_frame_pre got tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset got tx=%b busy=%b empty=%b want 1 0 1", tx, busy, empty);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if (tx !== 1'b1 || {tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL post_reset_idle%0d got=%b want=%b", i, {tx, busy, full, empty, overflow}, m_vec());
      end
    end
  endtask

  task automatic test_random();
    int rate, guard;
    for (int blk = 0; blk < 8; blk++) begin
      rate = $urandom_range(1, 30);
      for (int i = 0; i < 200; i++) begin
        out_write      = ($urandom_range(0, 99) < rate);
        out_data       = 16'($urandom);
        clear_overflow = ($urandom_range(0, 99) < 5);
        step();
        n_cmp++;
        if ({tx, busy, full, empty, overflow} !== m_vec()) begin
          n_err++;
          $display("FAIL random_b%0d_c%0d got=%b want=%b", blk, i, {tx, busy, full, empty, overflow}, m_vec());
        end
      end
    end
    out_write = 1'b0;
    clear_overflow = 1'b0;
    guard = 0;
    while ((mrem != 0 || mq.size() != 0) && guard < 3000) begin
      step();
      guard++;
      n_cmp++;
      if ({tx, busy, full, empty, overflow} !== m_vec()) begin
        n_err++;
        $display("FAIL random_drain%0d got=%b want=%b", guard, {tx, busy, full, empty, overflow}, m_vec());
      end
    end
    n_cmp++;
    if (guard >= 3000 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain_timeout busy=%b want=0", busy);
    end
  endtask

`ifdef OUT_PORT_TX_PARITY_EN
  task automatic test_parity();
    logic [15:0] words [2];
    logic        pbit  [2];
    int busy_cnt;
    words[0] = 16'h0007; pbit[0] = 1'b1;
    words[1] = 16'h0003; pbit[1] = 1'b0;
    for (int w = 0; w < 2; w++) begin
      busy_cnt = 0;
      out_write = 1'b1;
      out_data  = words[w];
      step();
      out_write = 1'b0;
      for (int i = 0; i < 80; i++) begin
        step();
        if (busy === 1'b1) busy_cnt++;
        n_cmp++;
        if ({tx, busy, full, empty, overflow} !== m_vec()) begin
          n_err++;
          $display("FAIL parity_w%0d_c%0d got=%b want=%b", w, i, {tx, busy, full, empty, overflow}, m_vec());
        end
        if (i >= 68 && i < 72) begin
          n_cmp++;
          if (tx !== pbit[w]) begin
            n_err++;
            $display("FAIL parity_bit_w%0d got=%b want=%b", w, tx, pbit[w]);
          end
        end
      end
      n_cmp++;
      if (busy_cnt != 76) begin
        n_err++;
        $display("FAIL parity_len_w%0d got=%0d want=76", w, busy_cnt);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill_overflow();
    test_stop_pop();
    test_reset_mid_frame();
    test_random();
`ifdef OUT_PORT_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
